// File: rtl/iterative_alu.sv
// Handshaked ALU: single-cycle ops plus iterative shift-add multiply / restoring divide.
// Define MDU_SIGNED_EN to enable signed MULT/DIV (opcodes 12/13); otherwise they decode as illegal.
module iterative_alu #(
   parameter int WIDTH = 32
) (
   input  logic             CLK,
   input  logic             nRST,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [3:0]       aluop,
   input  logic [WIDTH-1:0] port_A,
   input  logic [WIDTH-1:0] port_B,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] output_port,
   output logic [WIDTH-1:0] output_hi,
   output logic             negative,
   output logic             overflow,
   output logic             zero,
   output logic             div_zero,
   output logic             illegal
);

   localparam int SHW = $clog2(WIDTH);
   localparam logic [SHW-1:0]   LAST = SHW'(WIDTH - 1);
   localparam logic [WIDTH-1:0] ONES = '1;

   localparam logic [3:0] OP_SLL   = 4'd0;
   localparam logic [3:0] OP_SRL   = 4'd1;
   localparam logic [3:0] OP_ADD   = 4'd2;
   localparam logic [3:0] OP_SUB   = 4'd3;
   localparam logic [3:0] OP_AND   = 4'd4;
   localparam logic [3:0] OP_OR    = 4'd5;
   localparam logic [3:0] OP_XOR   = 4'd6;
   localparam logic [3:0] OP_NOR   = 4'd7;
   localparam logic [3:0] OP_SLT   = 4'd8;
   localparam logic [3:0] OP_SLTU  = 4'd9;
   localparam logic [3:0] OP_MULTU = 4'd10;
   localparam logic [3:0] OP_DIVU  = 4'd11;
`ifdef MDU_SIGNED_EN
   localparam logic [3:0] OP_MULT  = 4'd12;
   localparam logic [3:0] OP_DIV   = 4'd13;
   localparam logic [WIDTH-1:0] MIN = {1'b1, {(WIDTH-1){1'b0}}};
`endif

   typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
   state_t state, state_n;

   logic             accept, op_mdu, op_div, sgn_ovf;
   logic [WIDTH-1:0] sum, diff, alu_lo;
   logic             alu_ovf, alu_ill;
   logic [WIDTH-1:0] a_mag, b_mag;

   logic [WIDTH-1:0] res_lo, res_hi;
   logic             ovf_q, dz_q, ill_q;

   logic [WIDTH-1:0] work_hi, work_lo, m_op, a_orig;
   logic [SHW-1:0]   count;
   logic             is_div;
   logic [WIDTH:0]   mul_sum, div_trial;
   logic [WIDTH-1:0] it_hi, it_lo, fin_lo, fin_hi;

   // ---------------- control ----------------
   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) state <= IDLE;
      else       state <= state_n;
   end

   always_comb begin
      state_n   = state;
      in_ready  = 1'b0;
      out_valid = 1'b0;
      case (state)
         IDLE: begin
            in_ready = 1'b1;
            if (in_valid) state_n = op_mdu ? BUSY : DONE;
         end
         BUSY: begin
            if (count == LAST) state_n = DONE;
         end
         DONE: begin
            out_valid = 1'b1;
            in_ready  = out_ready;
            if (out_ready) state_n = in_valid ? (op_mdu ? BUSY : DONE) : IDLE;
         end
         default: state_n = IDLE;
      endcase
   end

   assign accept = in_valid & in_ready;

   // ---------------- decode ----------------
   always_comb begin
      op_mdu = 1'b0;
      op_div = 1'b0;
      case (aluop)
         OP_MULTU: op_mdu = 1'b1;
         OP_DIVU:  begin op_mdu = 1'b1; op_div = 1'b1; end
`ifdef MDU_SIGNED_EN
         OP_MULT:  op_mdu = 1'b1;
         OP_DIV:   begin op_mdu = 1'b1; op_div = 1'b1; end
`endif
         default: ;
      endcase
   end

`ifdef MDU_SIGNED_EN
   logic op_signed, neg_lo, neg_hi;
   assign op_signed = (aluop == OP_MULT) | (aluop == OP_DIV);
   assign a_mag     = (op_signed & port_A[WIDTH-1]) ? -port_A : port_A;
   assign b_mag     = (op_signed & port_B[WIDTH-1]) ? -port_B : port_B;
   // MIN / -1 iterates to quotient MIN, remainder 0 naturally; only the flag is special
   assign sgn_ovf   = (aluop == OP_DIV) & (port_A == MIN) & (port_B == ONES);
`else
   assign a_mag     = port_A;
   assign b_mag     = port_B;
   assign sgn_ovf   = 1'b0;
`endif

   // ---------------- single-cycle ops ----------------
   assign sum  = port_A + port_B;
   assign diff = port_A - port_B;

   always_comb begin
      alu_lo  = '0;
      alu_ovf = 1'b0;
      alu_ill = 1'b0;
      case (aluop)
         OP_SLL:  alu_lo = port_A << port_B[SHW-1:0];
         OP_SRL:  alu_lo = port_A >> port_B[SHW-1:0];
         OP_ADD: begin
            alu_lo  = sum;
            alu_ovf = (port_A[WIDTH-1] == port_B[WIDTH-1]) & (sum[WIDTH-1] != port_A[WIDTH-1]);
         end
         OP_SUB: begin
            alu_lo  = diff;
            alu_ovf = (port_A[WIDTH-1] != port_B[WIDTH-1]) & (diff[WIDTH-1] != port_A[WIDTH-1]);
         end
         OP_AND:  alu_lo = port_A & port_B;
         OP_OR:   alu_lo = port_A | port_B;
         OP_XOR:  alu_lo = port_A ^ port_B;
         OP_NOR:  alu_lo = ~(port_A | port_B);
         OP_SLT:  alu_lo = {{(WIDTH-1){1'b0}}, ($signed(port_A) < $signed(port_B))};
         OP_SLTU: alu_lo = {{(WIDTH-1){1'b0}}, (port_A < port_B)};
         OP_MULTU, OP_DIVU: ;
`ifdef MDU_SIGNED_EN
         OP_MULT, OP_DIV: ;
`endif
         default: alu_ill = 1'b1;
      endcase
   end

   // ---------------- iteration step ----------------
   // mul: {hi,lo} shifts right with hi accumulating the multiplicand when lo[0] is set
   // div: {rem,dividend} shifts left, one restoring subtract per cycle
   assign mul_sum   = {1'b0, work_hi} + (work_lo[0] ? {1'b0, m_op} : '0);
   assign div_trial = {work_hi, work_lo[WIDTH-1]} - {1'b0, m_op};

   always_comb begin
      if (is_div) begin
         it_hi = div_trial[WIDTH] ? {work_hi[WIDTH-2:0], work_lo[WIDTH-1]} : div_trial[WIDTH-1:0];
         it_lo = {work_lo[WIDTH-2:0], ~div_trial[WIDTH]};
      end else begin
         it_hi = mul_sum[WIDTH:1];
         it_lo = {mul_sum[0], work_lo[WIDTH-1:1]};
      end
   end

   always_comb begin
      fin_lo = it_lo;
      fin_hi = it_hi;
`ifdef MDU_SIGNED_EN
      if (is_div) begin
         if (neg_lo) fin_lo = -it_lo;
         if (neg_hi) fin_hi = -it_hi;
      end else if (neg_lo) begin
         {fin_hi, fin_lo} = -{it_hi, it_lo};
      end
`endif
      if (dz_q) begin
         fin_lo = ONES;
         fin_hi = a_orig;
      end
   end

   // ---------------- datapath registers ----------------
   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         res_lo  <= '0;
         res_hi  <= '0;
         ovf_q   <= 1'b0;
         dz_q    <= 1'b0;
         ill_q   <= 1'b0;
         work_hi <= '0;
         work_lo <= '0;
         m_op    <= '0;
         a_orig  <= '0;
         count   <= '0;
         is_div  <= 1'b0;
      end else if (accept) begin
         ill_q <= alu_ill;
         if (op_mdu) begin
            ovf_q   <= sgn_ovf;
            dz_q    <= op_div & (port_B == '0);
            is_div  <= op_div;
            count   <= '0;
            a_orig  <= port_A;
            work_hi <= '0;
            work_lo <= op_div ? a_mag : b_mag;
            m_op    <= op_div ? b_mag : a_mag;
         end else begin
            res_lo <= alu_lo;
            res_hi <= '0;
            ovf_q  <= alu_ovf;
            dz_q   <= 1'b0;
         end
      end else if (state == BUSY) begin
         work_hi <= it_hi;
         work_lo <= it_lo;
         count   <= count + 1'b1;
         if (count == LAST) begin
            res_lo <= fin_lo;
            res_hi <= fin_hi;
         end
      end
   end

`ifdef MDU_SIGNED_EN
   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         neg_lo <= 1'b0;
         neg_hi <= 1'b0;
      end else if (accept & op_mdu) begin
         neg_lo <= op_signed & (port_A[WIDTH-1] ^ port_B[WIDTH-1]);
         neg_hi <= op_signed & port_A[WIDTH-1];
      end
   end
`endif

   assign output_port = res_lo;
   assign output_hi   = res_hi;
   assign negative    = res_lo[WIDTH-1];
   assign zero        = (res_lo == '0);
   assign overflow    = ovf_q;
   assign div_zero    = dz_q;
   assign illegal     = ill_q;

endmodule

// File: tb/tb_iterative_alu.sv
// Bench for iterative_alu: directed scenarios with literal expectations, then randomized traffic
// checked every cycle against an arithmetic reference model.
module tb_iterative_alu;

   localparam int W = 32;
   localparam longint SMAX = 64'sd2147483647;
   localparam longint SMIN = -64'sd2147483648;

   logic          CLK = 1'b0, nRST = 1'b0, in_valid = 1'b0, out_ready = 1'b0;
   logic [3:0]    aluop = 4'd0;
   logic [W-1:0]  port_A = '0, port_B = '0;
   logic          in_ready, out_valid, negative, overflow, zero, div_zero, illegal;
   logic [W-1:0]  output_port, output_hi;

   iterative_alu #(.WIDTH(W)) dut (
      .CLK(CLK), .nRST(nRST), .in_valid(in_valid), .in_ready(in_ready), .aluop(aluop),
      .port_A(port_A), .port_B(port_B), .out_valid(out_valid), .out_ready(out_ready),
      .output_port(output_port), .output_hi(output_hi), .negative(negative),
      .overflow(overflow), .zero(zero), .div_zero(div_zero), .illegal(illegal)
   );

   always #10 CLK = ~CLK;

   typedef struct {
      logic [W-1:0] lo;
      logic [W-1:0] hi;
      logic         ovf;
      logic         dz;
      logic         ill;
      int           lat;
   } res_t;

   int total = 0;
   int bad   = 0;

   task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference: what each opcode must produce, from plain integer arithmetic
   function automatic res_t ref_op(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
      res_t r;
      longint s, q, m;
      logic [63:0] p;
      r.lo = '0; r.hi = '0; r.ovf = 1'b0; r.dz = 1'b0; r.ill = 1'b0; r.lat = 1;
      case (op)
         4'd0: r.lo = a << b[4:0];
         4'd1: r.lo = a >> b[4:0];
         4'd2: begin
            s = longint'($signed(a)) + longint'($signed(b));
            r.lo = a + b;
            r.ovf = (s > SMAX) || (s < SMIN);
         end
         4'd3: begin
            s = longint'($signed(a)) - longint'($signed(b));
            r.lo = a - b;
            r.ovf = (s > SMAX) || (s < SMIN);
         end
         4'd4: r.lo = a & b;
         4'd5: r.lo = a | b;
         4'd6: r.lo = a ^ b;
         4'd7: r.lo = ~(a | b);
         4'd8: r.lo = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
         4'd9: r.lo = (a < b) ? 32'd1 : 32'd0;
         4'd10: begin
            p = {32'b0, a} * {32'b0, b};
            r.lo = p[31:0]; r.hi = p[63:32]; r.lat = W + 1;
         end
         4'd11: begin
            r.lat = W + 1;
            if (b == 0) begin r.lo = '1; r.hi = a; r.dz = 1'b1; end
            else begin r.lo = a / b; r.hi = a % b; end
         end
`ifdef MDU_SIGNED_EN
         4'd12: begin
            s = longint'($signed(a)) * longint'($signed(b));
            p = s;
            r.lo = p[31:0]; r.hi = p[63:32]; r.lat = W + 1;
         end
         4'd13: begin
            r.lat = W + 1;
            if (b == 0) begin
               r.lo = '1; r.hi = a; r.dz = 1'b1;
            end else if (a == 32'h80000000 && b == 32'hFFFFFFFF) begin
               r.lo = a; r.hi = '0; r.ovf = 1'b1;
            end else begin
               q = longint'($signed(a)) / longint'($signed(b));
               m = longint'($signed(a)) % longint'($signed(b));
               p = q; r.lo = p[31:0];
               p = m; r.hi = p[31:0];
            end
         end
`endif
         default: r.ill = 1'b1;
      endcase
      return r;
   endfunction

   // Model: at most one outstanding result, visible once its latency has elapsed
   res_t nx, m_res;
   logic m_has = 1'b0;
   int   m_left = 0;

   always_comb nx = ref_op(aluop, port_A, port_B);

   always @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         m_has  <= 1'b0;
         m_left <= 0;
      end else begin
         if (m_has && m_left == 0 && out_ready) m_has <= 1'b0;
         else if (m_has && m_left > 0)          m_left <= m_left - 1;
         if (in_valid && (!m_has || (m_left == 0 && out_ready))) begin
            m_has  <= 1'b1;
            m_res  <= nx;
            m_left <= nx.lat - 1;
         end
      end
   end

   always @(negedge CLK) begin
      #2;
      if (!nRST) begin
         chk("rst out_valid", out_valid, 0);
         chk("rst output_port", output_port, 0);
         chk("rst output_hi", output_hi, 0);
         chk("rst zero", zero, 1);
         chk("rst flags", {negative, overflow, div_zero, illegal}, 0);
      end else begin
         chk("in_ready", in_ready, (!m_has || (m_left == 0 && out_ready)));
         chk("out_valid", out_valid, (m_has && m_left == 0));
         if (m_has && m_left == 0) begin
            chk("output_port", output_port, m_res.lo);
            chk("output_hi", output_hi, m_res.hi);
            chk("overflow", overflow, m_res.ovf);
            chk("div_zero", div_zero, m_res.dz);
            chk("illegal", illegal, m_res.ill);
            chk("negative", negative, m_res.lo[W-1]);
            chk("zero", zero, (m_res.lo == 0));
         end
      end
   end

   task automatic issue(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
      int n;
      @(negedge CLK);
      in_valid = 1'b1; aluop = op; port_A = a; port_B = b;
      n = 0;
      #3;
      while (!in_ready && n < 100) begin
         @(negedge CLK); #3; n++;
      end
      if (!in_ready) begin
         total++; bad++;
         $display("FAIL accept timeout: got in_ready=0 want 1 within 100 cycles");
      end
      @(posedge CLK);
      @(negedge CLK);
      in_valid = 1'b0; port_A = $urandom; port_B = $urandom; aluop = 4'($urandom_range(0, 15));
   endtask

   task automatic wait_result(output int lat);
      lat = 1;
      #3;
      while (!out_valid && lat < 100) begin
         @(negedge CLK); #3; lat++;
      end
      if (!out_valid) begin
         total++; bad++;
         $display("FAIL result timeout: got out_valid=0 want 1 within 100 cycles");
      end
   endtask

   task automatic retire();
      out_ready = 1'b1;
      @(negedge CLK);
      out_ready = 1'b0;
   endtask

   function automatic logic [W-1:0] pick();
      case ($urandom_range(0, 7))
         0: return 32'h0;
         1: return 32'h1;
         2: return 32'hFFFFFFFF;
         3: return 32'h80000000;
         4: return 32'h7FFFFFFF;
         5: return 32'($urandom_range(0, 40));
         default: return $urandom;
      endcase
   endfunction

   initial begin
      #1_500_000;
      $display("FAIL watchdog: got no finish want finish");
      $fatal(1, "watchdog");
   end

   initial begin
      res_t r;
      int lat;

      r = ref_op(4'd10, 32'hFFFFFFFF, 32'hFFFFFFFF);
      chk("model multu hi", r.hi, 32'hFFFFFFFE);
      r = ref_op(4'd11, 32'd100, 32'd7);
      chk("model divu q", r.lo, 32'd14);
      r = ref_op(4'd2, 32'h7FFFFFFF, 32'd1);
      chk("model add ovf", r.ovf, 1);
      r = ref_op(4'd8, 32'h80000000, 32'd0);
      chk("model slt", r.lo, 32'd1);

      repeat (3) @(negedge CLK);
      nRST = 1'b1;

      out_ready = 1'b1;
      issue(4'd2, 32'h7FFFFFFF, 32'd1);
      wait_result(lat);
      chk("add lat", lat, 1);
      chk("add result", output_port, 32'h80000000);
      chk("add overflow", overflow, 1);
      chk("add negative", negative, 1);
      @(negedge CLK);
      out_ready = 1'b0;

      issue(4'd10, 32'hFFFFFFFF, 32'hFFFFFFFF);
      wait_result(lat);
      chk("multu lat", lat, W + 1);
      chk("multu hi", output_hi, 32'hFFFFFFFE);
      chk("multu lo", output_port, 32'h00000001);
      retire();

      issue(4'd11, 32'd100, 32'd7);
      wait_result(lat);
      chk("divu lat", lat, W + 1);
      for (int i = 0; i < 5; i++) begin
         @(negedge CLK); #3;
         chk("hold quotient", output_port, 32'd14);
         chk("hold remainder", output_hi, 32'd2);
         chk("hold out_valid", out_valid, 1);
         chk("hold in_ready", in_ready, 0);
      end
      retire();

      issue(4'd11, 32'd5, 32'd0);
      wait_result(lat);
      chk("div0 lat", lat, W + 1);
      chk("div0 quotient", output_port, 32'hFFFFFFFF);
      chk("div0 remainder", output_hi, 32'd5);
      chk("div0 flag", div_zero, 1);
      retire();
      issue(4'd15, 32'd9, 32'd9);
      wait_result(lat);
      chk("illegal lat", lat, 1);
      chk("illegal flag", illegal, 1);
      chk("illegal zero", zero, 1);
      chk("illegal clears div_zero", div_zero, 0);
      retire();

      @(negedge CLK);
      in_valid = 1'b1; aluop = 4'd3; port_A = 32'd3; port_B = 32'd3; out_ready = 1'b1;
      #3 chk("b2b first ready", in_ready, 1);
      @(negedge CLK);
      aluop = 4'd8; port_A = 32'hFFFFFFFF; port_B = 32'd1;
      #3;
      chk("b2b sub valid", out_valid, 1);
      chk("b2b sub zero", zero, 1);
      chk("b2b ready", in_ready, 1);
      @(negedge CLK);
      in_valid = 1'b0;
      #3;
      chk("b2b slt valid", out_valid, 1);
      chk("b2b slt result", output_port, 32'd1);
      @(negedge CLK);
      out_ready = 1'b0;

      issue(4'd11, 32'd1000, 32'd3);
      repeat (8) @(negedge CLK);
      #4 nRST = 1'b0;
      #1;
      chk("midop rst out_valid", out_valid, 0);
      chk("midop rst output_port", output_port, 0);
      chk("midop rst output_hi", output_hi, 0);
      @(negedge CLK);
      nRST = 1'b1;
      #3;
      chk("post rst in_ready", in_ready, 1);
      chk("post rst out_valid", out_valid, 0);

`ifdef MDU_SIGNED_EN
      issue(4'd13, 32'hFFFFFFF9, 32'd2);
      wait_result(lat);
      chk("div lat", lat, W + 1);
      chk("div quotient", output_port, 32'hFFFFFFFD);
      chk("div remainder", output_hi, 32'hFFFFFFFF);
      retire();
      issue(4'd13, 32'h80000000, 32'hFFFFFFFF);
      wait_result(lat);
      chk("div min quotient", output_port, 32'h80000000);
      chk("div min remainder", output_hi, 32'd0);
      chk("div min overflow", overflow, 1);
      retire();
`else
      issue(4'd13, 32'hFFFFFFF9, 32'd2);
      wait_result(lat);
      chk("op13 lat", lat, 1);
      chk("op13 illegal", illegal, 1);
      retire();
`endif

      for (int i = 0; i < 4000; i++) begin
         @(negedge CLK);
         in_valid  = ($urandom_range(0, 9) < 7);
         aluop     = 4'($urandom_range(0, 15));
         port_A    = pick();
         port_B    = pick();
         out_ready = ($urandom_range(0, 9) < 6);
      end
      @(negedge CLK);
      in_valid  = 1'b0;
      out_ready = 1'b1;
      repeat (40) @(negedge CLK);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
